// File: rtl/stage_pipe_pkg.sv
// Shared constants and helpers for the elastic stage pipeline.
// Mode selectors and the occupancy counter width helper.
package stage_pipe_pkg;

  localparam int MODE_COLLAPSE = 0;
  localparam int MODE_LOCKSTEP = 1;

  // Bits needed to count 0..depth inclusive.
  function automatic int clog2_plus1(input int depth);
    int w;
    w = 0;
    while ((1 << w) < (depth + 1)) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage: W-bit data register plus its valid bit.
// Data loads only behind a valid source word, so it holds through bubbles.
module pipe_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         mv,
  input  logic         src_vld,
  input  logic [W-1:0] src_dat,
  output logic         vld,
  output logic [W-1:0] dat
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld <= 1'b0;
      dat <= '0;
    end else begin
      if (flush) begin
        vld <= 1'b0;
      end else if (mv) begin
        vld <= src_vld;
      end
      // Flush leaves the data word untouched.
      if (!flush && mv && src_vld) begin
        dat <= src_dat;
      end
    end
  end

endmodule

// File: rtl/elastic_stage_pipe.sv
// DEPTH-stage elastic register pipeline with valid/ready handshake,
// selectable stall policy, synchronous flush, taps and occupancy count.
module elastic_stage_pipe
  import stage_pipe_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int MODE  = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           in_valid,
  input  logic [W-1:0]                   in_data,
  output logic                           in_ready,
  output logic                           out_valid,
  output logic [W-1:0]                   out_data,
  input  logic                           out_ready,
  output logic [DEPTH*W-1:0]             taps,
  output logic [DEPTH-1:0]               tap_valid,
  output logic [clog2_plus1(DEPTH)-1:0]  occupancy
);

  localparam int OCC_W = clog2_plus1(DEPTH);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] mv;
  logic [DEPTH-1:0] src_vld;
  logic [DEPTH-1:0] vld_nxt;
  logic [W-1:0]     dat     [DEPTH];
  logic [W-1:0]     src_dat [DEPTH];
  logic             all_full;

  function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [OCC_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) cnt = cnt + OCC_W'(v[i]);
    return cnt;
  endfunction

  // A stage may advance when the output drains or any stage from it to the
  // output end is empty; lock-step mode only looks at the output stage.
  always_comb begin
    mv       = '0;
    all_full = 1'b1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      all_full = all_full & vld[i];
      if (MODE == MODE_LOCKSTEP) mv[i] = out_ready || !vld[DEPTH-1];
      else                       mv[i] = out_ready || !all_full;
    end
  end

  always_comb begin
    src_vld    = '0;
    src_vld[0] = in_valid;
    for (int i = 0; i < DEPTH; i++) src_dat[i] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_vld[i] = vld[i-1];
      src_dat[i] = dat[i-1];
    end
  end

  always_comb begin
    vld_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      vld_nxt[i] = flush ? 1'b0 : (mv[i] ? src_vld[i] : vld[i]);
    end
  end

  // Stage registers
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    pipe_stage_reg #(.W(W)) u_reg (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .mv      (mv[g]),
      .src_vld (src_vld[g]),
      .src_dat (src_dat[g]),
      .vld     (vld[g]),
      .dat     (dat[g])
    );
    assign taps[g*W +: W] = dat[g];
  end

  // Occupancy register tracks the popcount of the next valid vector
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) occupancy <= '0;
    else        occupancy <= popcount(vld_nxt);
  end

  assign in_ready  = mv[0] && !flush;
  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];
  assign tap_valid = vld;

endmodule
